acc_dest_dispatch: RTL

//  Write-side counterpart of the accumulator source select: routes the 8-bit accumulator value to its

---
 rtl/ark_acc_pkg.sv | 17 +
 rtl/acc_dest_dispatch_if.sv | 44 ++++
 rtl/acc_store_fifo.sv | 89 ++++++++
 rtl/acc_dest_dispatch.sv | 94 +++++++++
 4 files changed

// File: rtl/ark_acc_pkg.sv
// Shared types and widths for the accumulator write-side dispatch.
`default_nettype none

package ark_acc_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [2:0] {
    DEST_NONE = 3'b000,
    DEST_ALU  = 3'b001,
    DEST_REG  = 3'b010,
    DEST_MEM  = 3'b100
  } dest_t;

endpackage

`default_nettype wire

// File: rtl/acc_dest_dispatch_if.sv
// Dispatch-side bus of acc_dest_dispatch: core request, register/operand writes, store drain, load forward.
`default_nettype none

interface acc_dest_dispatch_if
  import ark_acc_pkg::*;
#(
  parameter int AW  = 8,
  parameter int RAW = 4
);

  logic             AccValid;
  dest_t            Dest;
  logic [ACC_W-1:0] Acc;
  logic [RAW-1:0]   RegAddr;
  logic [AW-1:0]    MemAddr;
  logic             Stall;
  logic             RegWrEn;
  logic [RAW-1:0]   RegWrAddr;
  logic [ACC_W-1:0] RegWrData;
  logic [ACC_W-1:0] Operand;
  logic             MemWrEn;
  logic [AW-1:0]    MemWrAddr;
  logic [ACC_W-1:0] MemWrData;
  logic             MemReady;
  logic             Drained;
  logic [AW-1:0]    LdAddr;
  logic             LdHit;
  logic [ACC_W-1:0] LdData;

  modport master (
    output AccValid, Dest, Acc, RegAddr, MemAddr, MemReady, LdAddr,
    input  Stall, RegWrEn, RegWrAddr, RegWrData, Operand,
           MemWrEn, MemWrAddr, MemWrData, Drained, LdHit, LdData
  );

  modport slave (
    input  AccValid, Dest, Acc, RegAddr, MemAddr, MemReady, LdAddr,
    output Stall, RegWrEn, RegWrAddr, RegWrData, Operand,
           MemWrEn, MemWrAddr, MemWrData, Drained, LdHit, LdData
  );

endinterface

`default_nettype wire

// File: rtl/acc_store_fifo.sv
// acc_store_fifo: DEPTH-entry store queue with optional newest-match load forwarding (ACC_DEST_FWD_EN).
// Rev 1.0
`default_nettype none

module acc_store_fifo
  import ark_acc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [AW-1:0]    push_addr,
  input  wire logic [ACC_W-1:0] push_data,
  input  wire logic             pop,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [AW-1:0]         head_addr,
  output logic [ACC_W-1:0]      head_data,
  input  wire logic [AW-1:0]    ld_addr,
  output logic                  ld_hit,
  output logic [ACC_W-1:0]      ld_data
);

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [ACC_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Storage carries no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ACC_DEST_FWD_EN
  logic [PW-1:0] scan_idx;

  // Walk oldest to newest so the last match seen is the entry closest to the tail.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (mem_addr[scan_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = mem_data[scan_idx];
      end
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/acc_dest_dispatch.sv
// acc_dest_dispatch: routes the accumulator to register file, ALU operand latch or buffered data-memory stores.
// Optional load forwarding from pending stores: ACC_DEST_FWD_EN. Rev 1.0
`default_nettype none

module acc_dest_dispatch
  import ark_acc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 8,
  parameter int RAW   = 4
) (
  input  wire logic          Clk,
  input  wire logic          Reset_n,
  acc_dest_dispatch_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             stall;
  logic             accept;
  logic             push;
  logic             pop;
  logic [AW-1:0]    head_addr;
  logic [ACC_W-1:0] head_data;
  logic             ld_hit;
  logic [ACC_W-1:0] ld_data;

  logic             reg_wr_en;
  logic [RAW-1:0]   reg_wr_addr;
  logic [ACC_W-1:0] reg_wr_data;
  logic [ACC_W-1:0] operand;

  // A full queue stalls even if the head leaves this cycle: no same-cycle pass-through.
  assign stall  = bus.AccValid & (bus.Dest == DEST_MEM) & full;
  assign accept = bus.AccValid & ~stall;
  assign push   = accept & (bus.Dest == DEST_MEM);
  assign pop    = ~empty & bus.MemReady;

  acc_store_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (push),
    .push_addr (bus.MemAddr),
    .push_data (bus.Acc),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .ld_addr   (bus.LdAddr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      operand     <= '0;
    end else begin
      reg_wr_en <= accept & (bus.Dest == DEST_REG);
      if (accept && (bus.Dest == DEST_REG)) begin
        reg_wr_addr <= bus.RegAddr;
        reg_wr_data <= bus.Acc;
      end
      if (accept && (bus.Dest == DEST_ALU)) begin
        operand <= bus.Acc;
      end
    end
  end

  assign bus.Stall     = stall;
  assign bus.RegWrEn   = reg_wr_en;
  assign bus.RegWrAddr = reg_wr_addr;
  assign bus.RegWrData = reg_wr_data;
  assign bus.Operand   = operand;
  assign bus.MemWrEn   = ~empty;
  assign bus.MemWrAddr = head_addr;
  assign bus.MemWrData = head_data;
  assign bus.Drained   = (count == '0);
  assign bus.LdHit     = ld_hit;
  assign bus.LdData    = ld_data;

endmodule

`default_nettype wire
